// File: rtl/uart_lite_if.sv
// AXI4-Lite bus bundle between a UART Lite initiator and the uart_lite_responder.
// The master modport is the initiator side and the slave modport is the responder side.
interface uart_lite_if;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  modport master (
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
           s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
           s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/uart_lite_responder.sv
// UART Lite register map behind an AXI4-Lite slave port.
// An RX byte FIFO is fed by the serial receiver, and a TX byte FIFO drains to the serializer.
module uart_lite_responder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  uart_lite_if.slave bus,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic [PW-1:0] rx_wr_nxt, rx_rd_nxt, tx_wr_nxt, tx_rd_nxt;
  logic          rx_empty, rx_full, tx_empty, tx_full;

  logic          ready_en;
  logic          rvalid_q, bvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q, bresp_q;
  logic          aw_held, w_held, w_strb0_q;
  logic [1:0]    aw_addr_q;
  logic [7:0]    w_data_q;
  logic          intr_en, overrun, irq_q;

  logic          ar_fire, aw_fire, w_fire, wr_exec, wr_en;
  logic [1:0]    rd_sel, wr_addr;
  logic [7:0]    wr_data;
  logic          wr_strb0;
  logic          rx_pop, rx_push, rx_clr, rx_ovf, stat_rd;
  logic          tx_pop, tx_push, tx_clr, tx_wr_hit, tx_push_ok, ctrl_wr;
  logic [31:0]   rd_data, stat_word;
  logic [1:0]    rd_resp, wr_resp;
  logic          intr_en_nxt, overrun_nxt;
  logic          unused_bits;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) &&
                    (rx_wr[DEPTH_LOG2-1:0] == rx_rd[DEPTH_LOG2-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) &&
                    (tx_wr[DEPTH_LOG2-1:0] == tx_rd[DEPTH_LOG2-1:0]);

  // Readies stay low through reset and rise on the first edge after release
  assign bus.s_arready = ready_en & ~rvalid_q;
  assign bus.s_awready = ready_en & ~aw_held & ~bvalid_q;
  assign bus.s_wready  = ready_en & ~w_held & ~bvalid_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;

  assign ar_fire = bus.s_arvalid & bus.s_arready;
  assign aw_fire = bus.s_awvalid & bus.s_awready;
  assign w_fire  = bus.s_wvalid & bus.s_wready;
  assign rd_sel  = bus.s_araddr[3:2];

  assign wr_addr  = aw_held ? aw_addr_q : bus.s_awaddr[3:2];
  assign wr_data  = w_held ? w_data_q : bus.s_wdata[7:0];
  assign wr_strb0 = w_held ? w_strb0_q : bus.s_wstrb[0];
  assign wr_exec  = (aw_held | aw_fire) & (w_held | w_fire) & ~bvalid_q;
  assign wr_en    = wr_exec & wr_strb0;

  assign tx_valid   = ~tx_empty;
  assign tx_data    = tx_empty ? 8'h00 : tx_mem[tx_rd[DEPTH_LOG2-1:0]];
  assign tx_pop     = tx_valid & tx_ready;
  assign tx_push_ok = ~tx_full | tx_pop;
  assign tx_wr_hit  = wr_en & (wr_addr == 2'd1);
  assign tx_push    = tx_wr_hit & tx_push_ok;
  assign ctrl_wr    = wr_en & (wr_addr == 2'd3);
  assign tx_clr     = ctrl_wr & wr_data[0];
  assign rx_clr     = ctrl_wr & wr_data[1];
  assign wr_resp    = (tx_wr_hit & ~tx_push_ok) ? RESP_SLVERR : RESP_OKAY;

  assign rx_pop  = ar_fire & (rd_sel == 2'd0) & ~rx_empty;
  assign stat_rd = ar_fire & (rd_sel == 2'd2);
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  // A clear in the same cycle swallows the byte without flagging overrun
  assign rx_ovf  = rx_valid & ~rx_push & ~rx_clr;

  assign stat_word = {26'h0, overrun, intr_en, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      2'd0: begin
        if (rx_empty) rd_resp = RESP_SLVERR;
        else          rd_data = {24'h0, rx_mem[rx_rd[DEPTH_LOG2-1:0]]};
      end
      2'd2:    rd_data = stat_word;
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    rx_wr_nxt = rx_wr + PW'(rx_push);
    rx_rd_nxt = rx_rd + PW'(rx_pop);
    tx_wr_nxt = tx_wr + PW'(tx_push);
    tx_rd_nxt = tx_rd + PW'(tx_pop);
    if (rx_clr) begin
      rx_wr_nxt = '0;
      rx_rd_nxt = '0;
    end
    if (tx_clr) begin
      tx_wr_nxt = '0;
      tx_rd_nxt = '0;
    end
    intr_en_nxt = ctrl_wr ? wr_data[4] : intr_en;
    overrun_nxt = rx_ovf ? 1'b1 : (stat_rd ? 1'b0 : overrun);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= rx_data;
    if (tx_push) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en <= 1'b0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
      intr_en  <= 1'b0;
      overrun  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rx_wr    <= rx_wr_nxt;
      rx_rd    <= rx_rd_nxt;
      tx_wr    <= tx_wr_nxt;
      tx_rd    <= tx_rd_nxt;
      intr_en  <= intr_en_nxt;
      overrun  <= overrun_nxt;
      irq_q    <= intr_en_nxt & (rx_wr_nxt != rx_rd_nxt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && bus.s_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held   <= 1'b0;
      aw_addr_q <= 2'd0;
      w_held    <= 1'b0;
      w_data_q  <= 8'h0;
      w_strb0_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_exec) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= bus.s_awaddr[3:2];
      end
      if (w_fire) begin
        w_held    <= 1'b1;
        w_data_q  <= bus.s_wdata[7:0];
        w_strb0_q <= bus.s_wstrb[0];
      end
      if (bvalid_q && bus.s_bready) bvalid_q <= 1'b0;
    end
  end

  assign irq = irq_q;

  assign unused_bits = ^{bus.s_araddr[31:4], bus.s_araddr[1:0], bus.s_awaddr[31:4],
                         bus.s_awaddr[1:0], bus.s_wdata[31:8], bus.s_wstrb[3:1]};
endmodule

// File: tb/tb_uart_lite_responder.sv
// Self-checking bench for uart_lite_responder: a register-access vector table, directed corner
// sequences, and randomized traffic checked against a queue-based model of the register map.
module tb_uart_lite_responder;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       irq;

  uart_lite_if bus();

  uart_lite_responder #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  bit         m_ien = 0;
  bit         m_ovr = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    return {26'h0, m_ovr, m_ien, m_tx.size() == 16, m_tx.size() == 0,
            m_rx.size() == 16, m_rx.size() != 0};
  endfunction

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    bus.s_araddr = a;
    bus.s_arvalid = 1'b1;
    while (!bus.s_arready && n < 50) begin @(negedge clk); n++; end
    check("arready_wait", bus.s_arready, 1);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    n = 0;
    while (!bus.s_rvalid && n < 50) begin @(negedge clk); n++; end
    check("rvalid_wait", bus.s_rvalid, 1);
    d = bus.s_rdata;
    r = bus.s_rresp;
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    @(negedge clk);
    bus.s_awaddr = a; bus.s_awvalid = 1'b1;
    bus.s_wdata = d; bus.s_wstrb = s; bus.s_wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      @(negedge clk);
      if (aw_hs) begin aw_done = 1; bus.s_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.s_wvalid = 1'b0;  end
      n++;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bus.s_bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid_wait", bus.s_bvalid, 1);
    resp = bus.s_bresp;
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
  endtask

  task automatic check_side(input string tag);
    check({tag, "_irq"}, irq, (m_ien && m_rx.size() != 0));
    check({tag, "_tx_valid"}, tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) check({tag, "_tx_data"}, tx_data, m_tx[0]);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    ed = 32'h0; er = 2'b00;
    case (a[3:2])
      2'd0: begin
        if (m_rx.size() == 0) er = 2'b10;
        else ed = {24'h0, m_rx.pop_front()};
      end
      2'd2: begin ed = stat_exp(); m_ovr = 0; end
      default: ed = 32'h0;
    endcase
    axi_read(a, d, r);
    check("rd_data", d, ed);
    check("rd_resp", r, er);
    check_side("rd");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r, er;
    er = 2'b00;
    if (s[0]) begin
      case (a[3:2])
        2'd1: begin
          if (m_tx.size() < 16) m_tx.push_back(d[7:0]);
          else er = 2'b10;
        end
        2'd3: begin
          if (d[0]) m_tx.delete();
          if (d[1]) m_rx.delete();
          m_ien = d[4];
        end
        default: er = 2'b00;
      endcase
    end
    axi_write(a, d, s, r);
    check("wr_resp", r, er);
    check_side("wr");
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (m_rx.size() < 16) m_rx.push_back(b);
    else m_ovr = 1;
    check_side("rxp");
  endtask

  task automatic tx_pop_one();
    @(negedge clk);
    check("txp_valid", tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) check("txp_data", tx_data, m_tx[0]);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (m_tx.size() != 0) void'(m_tx.pop_front());
    check_side("txp");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, bus.s_arready, 0);
    check({tag, "_awready"}, bus.s_awready, 0);
    check({tag, "_wready"}, bus.s_wready, 0);
    check({tag, "_rvalid"}, bus.s_rvalid, 0);
    check({tag, "_bvalid"}, bus.s_bvalid, 0);
    check({tag, "_rdata"}, bus.s_rdata, 0);
    check({tag, "_rresp_bresp"}, {bus.s_rresp, bus.s_bresp}, 0);
    check({tag, "_tx"}, {tx_valid, tx_data}, 0);
    check({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    logic [31:0] d, ed;
    logic [1:0] r;
    logic [7:0] got[$];
    logic [7:0] b;

    bus.s_araddr = 0; bus.s_arvalid = 0; bus.s_rready = 0;
    bus.s_awaddr = 0; bus.s_awvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0;
    bus.s_wvalid = 0; bus.s_bready = 0;
    rx_data = 0; rx_valid = 0; tx_ready = 0;

    // Reset state and ready release
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    #1 check("rel_arready", bus.s_arready, 0);
    @(negedge clk);
    check("rel_readies", {bus.s_arready, bus.s_awready, bus.s_wready}, 3'b111);

    // Register-access table from a clean state
    vecs.push_back('{0, 32'h0,    32'h0,  4'h0, 32'h0,  2'b10});
    vecs.push_back('{0, 32'h8,    32'h0,  4'h0, 32'h04, 2'b00});
    vecs.push_back('{0, 32'h4,    32'h0,  4'h0, 32'h0,  2'b00});
    vecs.push_back('{0, 32'hC,    32'h0,  4'h0, 32'h0,  2'b00});
    vecs.push_back('{1, 32'h4,    32'h41, 4'hF, 32'h0,  2'b00});
    vecs.push_back('{1, 32'h4,    32'h42, 4'h1, 32'h0,  2'b00});
    vecs.push_back('{1, 32'h4,    32'h99, 4'hE, 32'h0,  2'b00});
    vecs.push_back('{0, 32'h8,    32'h0,  4'h0, 32'h00, 2'b00});
    vecs.push_back('{1, 32'hC,    32'h10, 4'hF, 32'h0,  2'b00});
    vecs.push_back('{0, 32'h8,    32'h0,  4'h0, 32'h10, 2'b00});
    vecs.push_back('{1, 32'h0,    32'hFF, 4'hF, 32'h0,  2'b00});
    vecs.push_back('{1, 32'h8,    32'hFF, 4'hF, 32'h0,  2'b00});
    vecs.push_back('{0, 32'h1008, 32'h0,  4'h0, 32'h10, 2'b00});
    vecs.push_back('{1, 32'hC,    32'h01, 4'h1, 32'h0,  2'b00});
    vecs.push_back('{0, 32'h8,    32'h0,  4'h0, 32'h04, 2'b00});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
      end
    end

    // TX bytes come out in write order
    do_write(32'h4, 32'h41, 4'h1);
    do_write(32'h4, 32'h42, 4'h1);
    do_write(32'h4, 32'h43, 4'h1);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) got.push_back(tx_data);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("t1_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("t1_order", got[i], 8'h41 + 8'(i));
    m_tx.delete();

    // TX overflow
    for (int i = 0; i < 17; i++) do_write(32'h4, 32'h10 + 32'(i), 4'h1);
    do_read(32'h8);
    for (int i = 0; i < 16; i++) tx_pop_one();

    // RX empty read, then a single byte
    do_read(32'h0);
    rx_push(8'h5A);
    do_read(32'h0);

    // RX overrun and sticky-until-read flag
    for (int i = 0; i < 17; i++) rx_push(8'h80 + 8'(i));
    do_read(32'h8);
    do_read(32'h8);

    // Push and pop in the same cycle while full
    @(negedge clk);
    bus.s_araddr = 32'h0; bus.s_arvalid = 1'b1; rx_data = 8'hC3; rx_valid = 1'b1;
    check("pp_arready", bus.s_arready, 1);
    @(negedge clk);
    bus.s_arvalid = 1'b0; rx_valid = 1'b0;
    ed = {24'h0, m_rx.pop_front()};
    m_rx.push_back(8'hC3);
    check("pp_rvalid", bus.s_rvalid, 1);
    check("pp_rdata", bus.s_rdata, ed);
    check("pp_rresp", bus.s_rresp, 2'b00);
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    do_read(32'h8);

    // Overrun set in the same cycle as a STAT read: set survives
    @(negedge clk);
    bus.s_araddr = 32'h8; bus.s_arvalid = 1'b1; rx_data = 8'hEE; rx_valid = 1'b1;
    ed = stat_exp();
    @(negedge clk);
    bus.s_arvalid = 1'b0; rx_valid = 1'b0;
    m_ovr = 1;
    check("ovr_stat_rdata", bus.s_rdata, ed);
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    do_read(32'h8);
    do_read(32'h8);
    for (int i = 0; i < 17; i++) do_read(32'h0);

    // RX clear in the same cycle as a push into a full FIFO
    for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
    @(negedge clk);
    bus.s_awaddr = 32'hC; bus.s_awvalid = 1'b1; bus.s_wdata = 32'h12; bus.s_wstrb = 4'h1;
    bus.s_wvalid = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    check("clr_readies", {bus.s_awready, bus.s_wready}, 2'b11);
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; rx_valid = 1'b0;
    m_rx.delete();
    m_ien = 1;
    check("clr_bvalid", bus.s_bvalid, 1);
    check("clr_bresp", bus.s_bresp, 2'b00);
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    check_side("clr");
    do_read(32'h8);
    rx_push(8'h01);
    do_read(32'h0);

    // AW ahead of W, slow B acceptance
    @(negedge clk);
    bus.s_awaddr = 32'h4; bus.s_awvalid = 1'b1; bus.s_wdata = 32'hA5; bus.s_wstrb = 4'h1;
    check("t5_awready_idle", bus.s_awready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_awready_held", bus.s_awready, 0);
      check("t5_bvalid_early", bus.s_bvalid, 0);
    end
    bus.s_wvalid = 1'b1;
    check("t5_wready", bus.s_wready, 1);
    @(negedge clk);
    bus.s_wvalid = 1'b0;
    m_tx.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      check("t5_bvalid_hold", bus.s_bvalid, 1);
      check("t5_bresp", bus.s_bresp, 2'b00);
      check("t5_no_second_aw", {bus.s_awready, bus.s_wready}, 2'b00);
      @(negedge clk);
    end
    bus.s_awvalid = 1'b0;
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_single_b", bus.s_bvalid, 0);
      @(negedge clk);
    end
    check_side("t5");
    do_read(32'h8);

    // CTRL clear of both FIFOs, then reset in the middle of a read
    rx_push(8'h31);
    rx_push(8'h32);
    do_write(32'h4, 32'h51, 4'h1);
    do_write(32'hC, 32'h13, 4'h1);
    rx_push(8'h33);
    @(negedge clk);
    bus.s_araddr = 32'h0; bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check("t6_rvalid_pending", bus.s_rvalid, 1);
    rstn = 1'b0;
    #1 check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_hold");
    rstn = 1'b1;
    m_rx.delete(); m_tx.delete(); m_ien = 0; m_ovr = 0;
    @(negedge clk);
    do_read(32'h8);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int sel;
      bit fill;
      logic [31:0] hi;
      sel = $urandom_range(0, 99);
      fill = ((i / 60) % 2) == 0;
      hi = $urandom & 32'hFFFF_FFF3;
      if (sel < (fill ? 30 : 10)) begin
        b = 8'($urandom_range(0, 255));
        rx_push(b);
      end else if (sel < (fill ? 55 : 20)) begin
        do_write(hi | 32'h4, $urandom, ($urandom_range(0, 7) == 0) ? 4'hE : 4'hF);
      end else if (sel < (fill ? 65 : 50)) begin
        do_read(hi | 32'h0);
      end else if (sel < (fill ? 72 : 75)) begin
        tx_pop_one();
      end else if (sel < 85) begin
        do_read(hi | 32'h8);
      end else if (sel < 90) begin
        do_write(hi | 32'hC,
                 32'($urandom_range(0, 1) << 4) | (($urandom_range(0, 7) == 0) ? 32'h3 : 32'h0),
                 ($urandom_range(0, 5) == 0) ? 4'h0 : 4'h1);
      end else if (sel < 95) begin
        do_read(hi | (($urandom_range(0, 1) == 0) ? 32'h4 : 32'hC));
      end else begin
        do_write(hi | (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8), $urandom, 4'hF);
      end
    end
    do_read(32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
